// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and its environment.
// The master drives the run controls and memory handshake; the slave is the sequencer.
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             mem_access;
    logic             mem_ready;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             mem_req;
    logic             writeback_en;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, halt_req, mem_access, mem_ready,
        input  fetch_en, decode_en, execute_en, memory_en, mem_req, writeback_en,
        input  busy, halted, fault, instr_count, cycle_count
    );

    modport slave (
        input  start, halt_req, mem_access, mem_ready,
        output fetch_en, decode_en, execute_en, memory_en, mem_req, writeback_en,
        output busy, halted, fault, instr_count, cycle_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK
// with memory timeout fault, boundary-aligned halt and saturating counters.
module stage_sequencer #(
    parameter int unsigned INSTR_LIMIT = 500,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    stage_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_e;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(INSTR_LIMIT);

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [7:0]       wait_q, wait_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_inc_s;
    logic             fetch_en_q, decode_en_q, execute_en_q, memory_en_q, writeback_en_q;
    logic             busy_q, halted_q;
    logic             fetch_en_d, decode_en_d, execute_en_d, memory_en_d, writeback_en_d;
    logic             busy_d, halted_d;

    assign instr_inc_s = (instr_q == CNT_MAX) ? instr_q : instr_q + CNT_ONE;

    // Next-state, counter and flag computation.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        instr_d = instr_q;
        cycle_d = cycle_q;
        if (bus.halt_req && (state_q != S_HALT)) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end
        if (busy_q && (cycle_q != CNT_MAX)) begin
            cycle_d = cycle_q + CNT_ONE;
        end else begin
            cycle_d = cycle_q;
        end
        case (state_q)
            S_IDLE: begin
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (bus.start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                wait_d = 8'd0;
                if (bus.mem_access) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q >= WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WRITEBACK: begin
                instr_d = instr_inc_s;
                // A request raised during writeback itself still stops at this boundary.
                if (pend_q || bus.halt_req || ((INSTR_LIMIT != 0) && (instr_inc_s == LIMIT))) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        fetch_en_d     = (state_d == S_FETCH);
        decode_en_d    = (state_d == S_DECODE);
        execute_en_d   = (state_d == S_EXECUTE);
        memory_en_d    = (state_d == S_MEMORY);
        writeback_en_d = (state_d == S_WRITEBACK);
        busy_d         = fetch_en_d | decode_en_d | execute_en_d | memory_en_d | writeback_en_d;
        halted_d       = (state_d == S_HALT);
    end

    // State, flags, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pend_q         <= 1'b0;
            wait_q         <= 8'd0;
            fault_q        <= 1'b0;
            instr_q        <= {CNT_W{1'b0}};
            cycle_q        <= {CNT_W{1'b0}};
            fetch_en_q     <= 1'b0;
            decode_en_q    <= 1'b0;
            execute_en_q   <= 1'b0;
            memory_en_q    <= 1'b0;
            writeback_en_q <= 1'b0;
            busy_q         <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            wait_q         <= wait_d;
            fault_q        <= fault_d;
            instr_q        <= instr_d;
            cycle_q        <= cycle_d;
            fetch_en_q     <= fetch_en_d;
            decode_en_q    <= decode_en_d;
            execute_en_q   <= execute_en_d;
            memory_en_q    <= memory_en_d;
            writeback_en_q <= writeback_en_d;
            busy_q         <= busy_d;
            halted_q       <= halted_d;
        end
    end

    assign bus.fetch_en     = fetch_en_q;
    assign bus.decode_en    = decode_en_q;
    assign bus.execute_en   = execute_en_q;
    assign bus.memory_en    = memory_en_q;
    assign bus.mem_req      = memory_en_q;
    assign bus.writeback_en = writeback_en_q;
    assign bus.busy         = busy_q;
    assign bus.halted       = halted_q;
    assign bus.fault        = fault_q;
    assign bus.instr_count  = instr_q;
    assign bus.cycle_count  = cycle_q;
endmodule
